// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS-style integer pipeline.
//   XLEN / RW      : datapath width and register-index width
//   ALU_*          : 4-bit ALU control encodings {a_invert, b_negate, op[1:0]}
//   ctl_t          : control bits carried through ID/EX
//   idex_t         : complete ID/EX pipeline register contents
//   IDEX_BUBBLE    : ID/EX contents for a bubble (no architectural effect)
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [3:0] alu_ctl;
    } ctl_t;

    typedef struct packed {
        ctl_t            ctl;
        logic [RW-1:0]   rs;
        logic [RW-1:0]   rt;
        logic [RW-1:0]   dst;
        logic [XLEN-1:0] rs_data;
        logic [XLEN-1:0] rt_data;
        logic [XLEN-1:0] imm;
    } idex_t;

    // A bubble is all-zero: invalid, no writes, AND control, cleared fields.
    localparam idex_t IDEX_BUBBLE = '0;

endpackage : mips_pkg

// File: rtl/id_ex_stage_fwd_mux.sv
// -----------------------------------------------------------------------------
// fwd_mux
// Operand-forwarding selector for one source register.
//   src_i          : source register index being read in EX
//   exmem_we_i     : EX/MEM forwarding enable       (higher priority)
//   exmem_dst_i    : EX/MEM destination index
//   exmem_data_i   : EX/MEM result
//   memwb_we_i     : MEM/WB forwarding enable       (lower priority)
//   memwb_dst_i    : MEM/WB destination index
//   memwb_data_i   : MEM/WB write-back data
//   fallback_i     : value captured from the register file
//   data_o         : selected operand
// Register 0 is hard-wired zero, so it is never forwarded.
// -----------------------------------------------------------------------------
module fwd_mux
    import mips_pkg::*;
(
    input  logic [RW-1:0]   src_i,
    input  logic            exmem_we_i,
    input  logic [RW-1:0]   exmem_dst_i,
    input  logic [XLEN-1:0] exmem_data_i,
    input  logic            memwb_we_i,
    input  logic [RW-1:0]   memwb_dst_i,
    input  logic [XLEN-1:0] memwb_data_i,
    input  logic [XLEN-1:0] fallback_i,
    output logic [XLEN-1:0] data_o
);

    logic exmem_hit;
    logic memwb_hit;

    assign exmem_hit = exmem_we_i && (exmem_dst_i != '0) && (exmem_dst_i == src_i);
    assign memwb_hit = memwb_we_i && (memwb_dst_i != '0) && (memwb_dst_i == src_i);

    // The younger producer (EX/MEM) holds the newer value, so it wins.
    always_comb begin
        // NOTE: assigning a default first guarantees every path drives data_o, so no latch is inferred.
        data_o = fallback_i;
        if (exmem_hit) begin
            data_o = exmem_data_i;
        end else if (memwb_hit) begin
            data_o = memwb_data_i;
        end
    end

endmodule : fwd_mux

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register plus operand forwarding for the EX-stage ALU.
// Inputs:
//   clk, rst               : clock, asynchronous active-high reset
//   stall, flush           : hold contents / load a bubble (flush wins)
//   id_*                   : decoded instruction fields from ID
//   exmem_*, memwb_*       : live forwarding buses from later stages
// Outputs:
//   alu_a, alu_b, alu_ctl  : final ALU operands and control
//   ex_store_data          : forwarded rt value for stores
//   ex_valid, ex_*         : registered control bits and destination
//   load_use               : combinational load-use hazard request
// -----------------------------------------------------------------------------
module id_ex_stage
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_rs_data,
    input  logic [XLEN-1:0] id_rt_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RW-1:0]   id_rs,
    input  logic [RW-1:0]   id_rt,
    input  logic [RW-1:0]   id_dst,
    input  logic [3:0]      id_alu_ctl,
    input  logic            id_alu_src,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_mem_to_reg,
    input  logic            exmem_reg_write,
    input  logic [RW-1:0]   exmem_dst,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [RW-1:0]   memwb_dst,
    input  logic [XLEN-1:0] memwb_data,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctl,
    output logic [XLEN-1:0] ex_store_data,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_mem_to_reg,
    output logic [RW-1:0]   ex_dst,
    output logic            load_use
);

    idex_t           idex_q;
    idex_t           idex_d;
    logic [XLEN-1:0] rt_fwd;

    // Next-state selection: flush > stall > capture.
    always_comb begin
        idex_d = idex_q;
        if (flush) begin
            idex_d = IDEX_BUBBLE;
        end else if (!stall) begin
            idex_d.ctl.valid      = id_valid;
            // Gating with id_valid keeps an invalid slot from ever writing state.
            idex_d.ctl.reg_write  = id_valid & id_reg_write;
            idex_d.ctl.mem_read   = id_valid & id_mem_read;
            idex_d.ctl.mem_write  = id_valid & id_mem_write;
            idex_d.ctl.mem_to_reg = id_valid & id_mem_to_reg;
            idex_d.ctl.alu_src    = id_alu_src;
            idex_d.ctl.alu_ctl    = id_alu_ctl;
            idex_d.rs             = id_rs;
            idex_d.rt             = id_rt;
            idex_d.dst            = id_dst;
            idex_d.rs_data        = id_rs_data;
            idex_d.rt_data        = id_rt_data;
            idex_d.imm            = id_imm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignment keeps every flop sampling pre-edge values, independent of block order.
            idex_q <= IDEX_BUBBLE;
        end else begin
            idex_q <= idex_d;
        end
    end

    fwd_mux u_fwd_rs (
        .src_i        (idex_q.rs),
        .exmem_we_i   (exmem_reg_write),
        .exmem_dst_i  (exmem_dst),
        .exmem_data_i (exmem_result),
        .memwb_we_i   (memwb_reg_write),
        .memwb_dst_i  (memwb_dst),
        .memwb_data_i (memwb_data),
        .fallback_i   (idex_q.rs_data),
        .data_o       (alu_a)
    );

    fwd_mux u_fwd_rt (
        .src_i        (idex_q.rt),
        .exmem_we_i   (exmem_reg_write),
        .exmem_dst_i  (exmem_dst),
        .exmem_data_i (exmem_result),
        .memwb_we_i   (memwb_reg_write),
        .memwb_dst_i  (memwb_dst),
        .memwb_data_i (memwb_data),
        .fallback_i   (idex_q.rt_data),
        .data_o       (rt_fwd)
    );

    assign alu_b         = idex_q.ctl.alu_src ? idex_q.imm : rt_fwd;
    assign ex_store_data = rt_fwd;

    assign alu_ctl       = idex_q.ctl.alu_ctl;
    assign ex_valid      = idex_q.ctl.valid;
    assign ex_reg_write  = idex_q.ctl.reg_write;
    assign ex_mem_read   = idex_q.ctl.mem_read;
    assign ex_mem_write  = idex_q.ctl.mem_write;
    assign ex_mem_to_reg = idex_q.ctl.mem_to_reg;
    assign ex_dst        = idex_q.dst;

    // rt is checked even for immediate-form instructions: a spurious stall is
    // cheaper than decoding which operands ID actually consumes.
    assign load_use = idex_q.ctl.valid && idex_q.ctl.mem_read && (idex_q.dst != '0) &&
                      ((idex_q.dst == id_rs) || (idex_q.dst == id_rt));

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage: directed scenarios with constant
// expectations, then randomized traffic against a behavioural model.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic [3:0]  id_alu_ctl;
    logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_dst, memwb_dst;
    logic [31:0] exmem_result, memwb_data;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_ctl;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [4:0]  ex_dst;
    logic        load_use;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .id_valid        (id_valid),
        .id_rs_data      (id_rs_data),
        .id_rt_data      (id_rt_data),
        .id_imm          (id_imm),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_dst          (id_dst),
        .id_alu_ctl      (id_alu_ctl),
        .id_alu_src      (id_alu_src),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_mem_write    (id_mem_write),
        .id_mem_to_reg   (id_mem_to_reg),
        .exmem_reg_write (exmem_reg_write),
        .exmem_dst       (exmem_dst),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_dst       (memwb_dst),
        .memwb_data      (memwb_data),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_ctl         (alu_ctl),
        .ex_store_data   (ex_store_data),
        .ex_valid        (ex_valid),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_mem_to_reg   (ex_mem_to_reg),
        .ex_dst          (ex_dst),
        .load_use        (load_use)
    );

    // Behavioural picture of the instruction sitting in EX.
    typedef struct {
        bit       valid, rw, mr, mw, m2r, src;
        bit [3:0] ctl;
        bit [4:0] rs, rt, dst;
        bit [31:0] rs_data, rt_data, imm;
    } instr_t;

    instr_t ex_m;

    task automatic clear_model();
        ex_m = '{default: 0};
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            clear_model();
        end else if (flush) begin
            clear_model();
        end else if (!stall) begin
            ex_m.valid   = id_valid;
            ex_m.rw      = id_valid && id_reg_write;
            ex_m.mr      = id_valid && id_mem_read;
            ex_m.mw      = id_valid && id_mem_write;
            ex_m.m2r     = id_valid && id_mem_to_reg;
            ex_m.src     = id_alu_src;
            ex_m.ctl     = id_alu_ctl;
            ex_m.rs      = id_rs;
            ex_m.rt      = id_rt;
            ex_m.dst     = id_dst;
            ex_m.rs_data = id_rs_data;
            ex_m.rt_data = id_rt_data;
            ex_m.imm     = id_imm;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Newest producer of a nonzero register wins; otherwise the file value.
    function automatic bit [31:0] operand(input bit [4:0] r, input bit [31:0] file_val);
        if (r == 0) return file_val;
        if (exmem_reg_write && exmem_dst == r) return exmem_result;
        if (memwb_reg_write && memwb_dst == r) return memwb_data;
        return file_val;
    endfunction

    task automatic check_model();
        bit [31:0] b_rt;
        bit        lu;
        b_rt = operand(ex_m.rt, ex_m.rt_data);
        lu   = ex_m.valid && ex_m.mr && ex_m.dst != 0 && (ex_m.dst == id_rs || ex_m.dst == id_rt);
        check("m_alu_a",     alu_a,         operand(ex_m.rs, ex_m.rs_data));
        check("m_alu_b",     alu_b,         ex_m.src ? ex_m.imm : b_rt);
        check("m_store",     ex_store_data, b_rt);
        check("m_alu_ctl",   32'(alu_ctl),  32'(ex_m.ctl));
        check("m_ctl_bits",  {27'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
                             {27'd0, ex_m.valid, ex_m.rw, ex_m.mr, ex_m.mw, ex_m.m2r});
        check("m_dst",       32'(ex_dst),   32'(ex_m.dst));
        check("m_load_use",  32'(load_use), 32'(lu));
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; id_valid = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_dst = 0; id_alu_ctl = 0;
        id_alu_src = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        exmem_reg_write = 0; exmem_dst = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_dst = 0; memwb_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        #12;
        check("rst_ex_valid", 32'(ex_valid), 0);
        check("rst_alu_ctl",  32'(alu_ctl),  0);
        check("rst_alu_a",    alu_a,         0);
        @(negedge clk);
        rst = 0;
        tick();

        // Plain capture, no forwarding.
        id_valid = 1; id_rs = 1; id_rt = 2; id_dst = 3; id_reg_write = 1;
        id_rs_data = 32'h5; id_rt_data = 32'h3; id_alu_ctl = 4'b0110;
        tick();
        check("cap_alu_a",    alu_a,         32'h5);
        check("cap_alu_b",    alu_b,         32'h3);
        check("cap_alu_ctl",  32'(alu_ctl),  32'h6);
        check("cap_valid",    32'(ex_valid), 1);
        check_model();

        // Double forward: EX/MEM beats MEM/WB.
        id_rs = 8; id_rs_data = 32'h11;
        tick();
        exmem_reg_write = 1; exmem_dst = 8; exmem_result = 32'hAAAA_0000;
        memwb_reg_write = 1; memwb_dst = 8; memwb_data = 32'h1234_5678;
        #1 check("fwd_exmem", alu_a, 32'hAAAA_0000);
        exmem_reg_write = 0;
        #1 check("fwd_memwb", alu_a, 32'h1234_5678);
        check_model();

        // Register 0 is never forwarded.
        idle_inputs();
        id_valid = 1; id_rs = 0;
        tick();
        exmem_reg_write = 1; exmem_dst = 0; exmem_result = 32'hFFFF_FFFF;
        #1 check("r0_no_fwd", alu_a, 0);

        // Immediate selects B; store data still forwarded.
        idle_inputs();
        id_valid = 1; id_alu_src = 1; id_imm = 32'hFFFF_FFFC; id_rt = 9; id_rt_data = 32'h77;
        tick();
        memwb_reg_write = 1; memwb_dst = 9; memwb_data = 32'h55;
        #1 check("imm_alu_b",  alu_b,         32'hFFFF_FFFC);
        check("imm_store",     ex_store_data, 32'h55);

        // Load-use detection, then stall+flush together inserts a bubble.
        idle_inputs();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1; id_dst = 4;
        tick();
        id_mem_read = 0; id_dst = 7; id_rs = 4; id_rt = 2;
        #1 check("load_use_hit", 32'(load_use), 1);
        stall = 1; flush = 1;
        tick();
        check("lu_flush_valid", 32'(ex_valid),     0);
        check("lu_flush_rw",    32'(ex_reg_write), 0);
        check("lu_flush_mr",    32'(ex_mem_read),  0);
        check("lu_cleared",     32'(load_use),     0);

        // Stall holds everything for three cycles.
        idle_inputs();
        id_valid = 1; id_rs = 6; id_rs_data = 32'h42; id_alu_ctl = 4'b0010; id_dst = 5; id_reg_write = 1;
        tick();
        stall = 1;
        id_rs_data = 32'hDEAD_BEEF; id_alu_ctl = 4'b1100; id_dst = 9; id_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_alu_a",   alu_a,            32'h42);
            check("stall_alu_ctl", 32'(alu_ctl),     32'h2);
            check("stall_dst",     32'(ex_dst),      32'h5);
            check("stall_valid",   32'(ex_valid),    1);
        end

        // Invalid ID never writes.
        idle_inputs();
        id_valid = 0; id_reg_write = 1; id_mem_write = 1;
        tick();
        check("inv_rw",    32'(ex_reg_write), 0);
        check("inv_mw",    32'(ex_mem_write), 0);

        // Asynchronous reset between edges.
        id_valid = 1; id_reg_write = 1; id_alu_ctl = 4'b0111; id_dst = 12; id_rs_data = 32'h99;
        tick();
        check("pre_rst_valid", 32'(ex_valid), 1);
        #2 rst = 1;
        #1;
        check("arst_valid",   32'(ex_valid), 0);
        check("arst_alu_ctl", 32'(alu_ctl),  0);
        check("arst_dst",     32'(ex_dst),   0);
        check("arst_alu_a",   alu_a,         0);
        @(negedge clk);
        rst = 0;
        idle_inputs();
        tick();

        // Randomized traffic; small index range makes matches common.
        for (int n = 0; n < 400; n++) begin
            stall           = ($urandom_range(0, 7) == 0);
            flush           = ($urandom_range(0, 9) == 0);
            id_valid        = ($urandom_range(0, 3) != 0);
            id_rs           = 5'($urandom_range(0, 4));
            id_rt           = 5'($urandom_range(0, 4));
            id_dst          = 5'($urandom_range(0, 4));
            id_rs_data      = $urandom;
            id_rt_data      = $urandom;
            id_imm          = $urandom;
            id_alu_ctl      = 4'($urandom);
            id_alu_src      = 1'($urandom);
            id_reg_write    = 1'($urandom);
            id_mem_read     = 1'($urandom);
            id_mem_write    = 1'($urandom);
            id_mem_to_reg   = 1'($urandom);
            exmem_reg_write = 1'($urandom);
            exmem_dst       = 5'($urandom_range(0, 4));
            exmem_result    = $urandom;
            memwb_reg_write = 1'($urandom);
            memwb_dst       = 5'($urandom_range(0, 4));
            memwb_data      = $urandom;
            #1 check_model();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_id_ex_stage
